// File: rtl/hack_boot_ctrl.sv
// Boot and run controller for the Hack core: streams a length-prefixed program
// into instruction ROM, releases the core, and supervises it until a halt cause.
module hack_boot_ctrl #(
  parameter int ROM_AW     = 15,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              core_xrst,
  input  logic [15:0]       core_pc,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_count
);

  // Wide enough for both a 16-bit host word and the ROM depth itself.
  localparam int NW = (ROM_AW + 1 > 17) ? ROM_AW + 1 : 17;
  localparam logic [NW-1:0]    ONE_NW   = NW'(1'b1);
  localparam logic [NW-1:0]    DEPTH    = ONE_NW << ROM_AW;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  localparam logic [1:0] CAUSE_STOP = 2'd0;
  localparam logic [1:0] CAUSE_PC   = 2'd1;
  localparam logic [1:0] CAUSE_TMO  = 2'd2;
  localparam logic [1:0] CAUSE_LEN  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN    = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [NW-1:0]     len_q, len_d;
  logic [NW-1:0]     idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              rom_we_q, rom_we_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [15:0]       rom_wdata_q, rom_wdata_d;
  logic              core_xrst_q, core_xrst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              fire_s;
  logic [NW-1:0]     data_ext_s;
  logic [NW-1:0]     pc_ext_s;

  assign fire_s     = in_valid && in_ready_q;
  assign data_ext_s = NW'(in_data);
  assign pc_ext_s   = NW'(core_pc);

  // State and registered-output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= 16'h0000;
      core_xrst_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cause_q     <= 2'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      core_xrst_q <= core_xrst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        cause_d = CAUSE_STOP;
        idx_d   = '0;
        if (start) begin
          state_d = S_LEN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (stop) begin
          state_d = S_HALT;
          cause_d = CAUSE_STOP;
        end else if (fire_s) begin
          if ((data_ext_s >= ONE_NW) && (data_ext_s <= DEPTH)) begin
            len_d   = data_ext_s;
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_HALT;
            cause_d = CAUSE_LEN;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_d = S_HALT;
          cause_d = CAUSE_STOP;
        end else if (fire_s) begin
          rom_we_d    = 1'b1;
          rom_addr_d  = idx_q[ROM_AW-1:0];
          rom_wdata_d = in_data;
          idx_d       = idx_q + ONE_NW;
          if (idx_q == (len_q - ONE_NW)) begin
            state_d = S_SETTLE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_SETTLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (stop) begin
          state_d = S_HALT;
          cause_d = CAUSE_STOP;
        end else if (pc_ext_s >= len_q) begin
          state_d = S_HALT;
          cause_d = CAUSE_PC;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HALT;
          cause_d = CAUSE_TMO;
        end else begin
          state_d = S_RUN;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_LEN;
          cnt_d   = '0;
          cause_d = CAUSE_STOP;
          idx_d   = '0;
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d == S_LEN) || (state_d == S_LOAD);
    busy_d      = (state_d == S_LEN) || (state_d == S_LOAD) ||
                  (state_d == S_SETTLE) || (state_d == S_RUN);
    done_d      = (state_d == S_HALT);
    core_xrst_d = (state_d == S_RUN);
  end

  assign in_ready    = in_ready_q;
  assign rom_we      = rom_we_q;
  assign rom_addr    = rom_addr_q;
  assign rom_wdata   = rom_wdata_q;
  assign core_xrst   = core_xrst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halt_cause  = cause_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Directed bench for hack_boot_ctrl: ROM writes are checked against a queue of
// expected writes filled as each accepted word is driven.
module tb_hack_boot_ctrl;

  localparam int ROM_AW     = 3;
  localparam int CNT_W      = 16;
  localparam int MAX_CYCLES = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stop;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              in_ready;
  logic              rom_we;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_wdata;
  logic              core_xrst;
  logic [15:0]       core_pc;
  logic              busy;
  logic              done;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  cycle_count;

  hack_boot_ctrl #(
    .ROM_AW(ROM_AW), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .core_xrst(core_xrst), .core_pc(core_pc), .busy(busy), .done(done),
    .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ROM_AW-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] prog[0:15];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge and retire any expected ROM write.
  task automatic tick();
    wr_t e;
    @(posedge clk);
    #1;
    check("rom_we", {31'd0, rom_we}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
    if (rom_we && (exp_q.size() > 0)) begin
      e = exp_q.pop_front();
      check("rom_addr", {29'd0, rom_addr}, {29'd0, e.addr});
      check("rom_wdata", {16'd0, rom_wdata}, {16'd0, e.data});
    end
  endtask

  task automatic push_wr(input int k, input logic [15:0] d);
    wr_t e;
    e.addr = k[ROM_AW-1:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Start, send length n, then n words back to back; ends in SETTLE.
  task automatic load_prog(input int n);
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = n[15:0];
    tick();
    for (int k = 0; k < n; k++) begin
      in_data = prog[k];
      push_wr(k, prog[k]);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
    check({tag, "_rom_addr"},  {29'd0, rom_addr}, 32'd0);
    check({tag, "_rom_wdata"}, {16'd0, rom_wdata}, 32'd0);
    check({tag, "_core_xrst"}, {31'd0, core_xrst}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
    check({tag, "_done"},      {31'd0, done}, 32'd0);
    check({tag, "_cause"},     {30'd0, halt_cause}, 32'd0);
    check({tag, "_count"},     {16'd0, cycle_count}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    in_valid = 1'b0; in_data = 16'h0000; core_pc = 16'h0000;
    tick();
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Load 3 words with valid held high
    prog[0] = 16'h0005; prog[1] = 16'hEC10; prog[2] = 16'hE308;
    load_prog(3);
    check("settle_in_ready", {31'd0, in_ready}, 32'd0);
    check("settle_xrst", {31'd0, core_xrst}, 32'd0);
    check("settle_busy", {31'd0, busy}, 32'd1);
    tick();
    check("run_xrst", {31'd0, core_xrst}, 32'd1);
    check("run_count0", {16'd0, cycle_count}, 32'd0);

    // pc walks 0,1,2,3 -> out of range on the fourth RUN cycle
    core_pc = 16'd0; tick();
    core_pc = 16'd1; tick();
    core_pc = 16'd2; tick();
    core_pc = 16'd3; tick();
    check("pc_done", {31'd0, done}, 32'd1);
    check("pc_cause", {30'd0, halt_cause}, 32'd1);
    check("pc_count", {16'd0, cycle_count}, 32'd4);
    check("pc_xrst", {31'd0, core_xrst}, 32'd0);
    core_pc = 16'd0;
    tick();
    check("pc_hold_count", {16'd0, cycle_count}, 32'd4);

    // Timeout with pc parked at 0
    prog[0] = 16'hAAAA; prog[1] = 16'h5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_count", {16'd0, cycle_count}, 32'd0);
    check("restart_cause", {30'd0, halt_cause}, 32'd0);
    in_valid = 1'b1; in_data = 16'd2;
    tick();
    for (int k = 0; k < 2; k++) begin
      in_data = prog[k];
      push_wr(k, prog[k]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) tick();
    check("tmo_busy", {31'd0, busy}, 32'd1);
    check("tmo_count7", {16'd0, cycle_count}, 32'd7);
    tick();
    check("tmo_done", {31'd0, done}, 32'd1);
    check("tmo_cause", {30'd0, halt_cause}, 32'd2);
    check("tmo_count", {16'd0, cycle_count}, 32'd8);

    // Bad lengths 0 and 2^ROM_AW+1
    for (int b = 0; b < 2; b++) begin
      start = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b1;
      in_data = (b == 0) ? 16'd0 : 16'd9;
      tick();
      in_valid = 1'b0;
      check("badlen_done", {31'd0, done}, 32'd1);
      check("badlen_cause", {30'd0, halt_cause}, 32'd3);
      check("badlen_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end

    // Full-depth load
    for (int k = 0; k < 8; k++) prog[k] = 16'h1000 + 16'(k * 3);
    load_prog(8);
    tick();
    check("full_xrst", {31'd0, core_xrst}, 32'd1);
    check("full_busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("full_stop_cause", {30'd0, halt_cause}, 32'd0);
    check("full_stop_done", {31'd0, done}, 32'd1);

    // Toggled valid during a 5-word load
    for (int k = 0; k < 5; k++) prog[k] = 16'h2200 + 16'(k);
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 16'd5;
    tick();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = prog[k];
      push_wr(k, prog[k]);
      tick();
      in_valid = 1'b0; in_data = 16'hDEAD;
      tick();
    end
    check("tog_xrst", {31'd0, core_xrst}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("tog_cause", {30'd0, halt_cause}, 32'd0);
    check("tog_count", {16'd0, cycle_count}, 32'd1);

    // Stop after 2 of 5 words
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 16'd5;
    tick();
    for (int k = 0; k < 2; k++) begin
      in_data = prog[k];
      push_wr(k, prog[k]);
      tick();
    end
    stop = 1'b1; in_data = prog[2];
    tick();
    stop = 1'b0;
    check("abort_done", {31'd0, done}, 32'd1);
    check("abort_cause", {30'd0, halt_cause}, 32'd0);
    tick();
    tick();
    in_valid = 1'b0;

    // Reset while running, then reload from address 0
    prog[0] = 16'h0A0A; prog[1] = 16'h0B0B; prog[2] = 16'h0C0C;
    load_prog(3);
    tick();
    tick();
    tick();
    check("prerst_count", {16'd0, cycle_count}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("midrst");
    prog[0] = 16'h7777; prog[1] = 16'h8888;
    load_prog(2);
    tick();
    check("reload_xrst", {31'd0, core_xrst}, 32'd1);
    tick();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
